// File: rtl/detector_pkg.sv
// Shared constants for the detector event packetizer: record layout, readout header,
// flag bit positions and detector FSM encoding.
package detector_pkg;

  localparam int RECORD_W  = 112;

  // Record layout, MSB first: {start_time, peak, width, flags}
  localparam int FLAGS_LSB = 0;
  localparam int WIDTH_LSB = 16;
  localparam int PEAK_LSB  = 32;
  localparam int TIME_LSB  = 48;

  localparam logic [7:0] HEADER = 8'hA5;

  localparam int FLAG_WIDTH_SAT    = 0;
  localparam int FLAG_THR_CHANGED  = 1;

  typedef logic [RECORD_W-1:0] record_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_PULSE = 2'd1,
    ST_EMIT     = 2'd2
  } det_state_t;

endpackage

// File: rtl/detector_event_packetizer_if.sv
// Readout port of the packetizer: 32-bit words with valid/ready handshake and last marker.
interface detector_event_packetizer_if;
  logic [31:0] event_data_p;
  logic        event_valid_p;
  logic        event_ready_p;
  logic        event_last_p;

  modport master (output event_data_p, event_valid_p, event_last_p, input event_ready_p);
  modport slave  (input event_data_p, event_valid_p, event_last_p, output event_ready_p);
endinterface

// File: rtl/event_record_fifo.sv
// Register-based single-clock FIFO for event records; push while full is refused even
// if a pop happens in the same cycle.
module event_record_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 112
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [6:0]       level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [6:0]       count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == 7'(DEPTH));
  assign empty    = (count == 7'd0);
  assign level    = count;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + 7'(push_ok) - 7'(pop_ok);
    end
  end
endmodule

// File: rtl/detector_event_packetizer.sv
// Detects threshold pulses on the ADC stream, buffers 112-bit event records and reads them
// out as four 32-bit words. Optional macro PULSE_MIN_WIDTH_FILTER_EN drops narrow pulses.
module detector_event_packetizer
  import detector_pkg::*;
#(
  parameter int EVENT_FIFO_DEPTH = 16,
  parameter int MIN_PULSE_WIDTH  = 3
) (
  input  logic        clk210_p,
  input  logic        reset_n_p,
  input  logic        adc_sample_valid_p,
  input  logic [15:0] adc_sample_data_p,
  input  logic [15:0] adc_threshold_p,
  input  logic [63:0] timekeeper_time_p,
  input  logic        timekeeper_ready_p,
  detector_event_packetizer_if.master readout,
  output logic [15:0] event_drop_count_p,
  output logic [6:0]  fifo_level_p
);
  det_state_t  state;
  logic [63:0] start_time;
  logic [15:0] peak;
  logic [15:0] width;
  logic [15:0] start_thr;
  logic        thr_changed;
  logic        above;
  logic        keep;
  logic        push;
  record_t     record;

  logic        fifo_full;
  logic        fifo_empty;
  record_t     fifo_rdata;

  logic        ser_valid;
  logic [1:0]  word_idx;
  record_t     cur;
  logic [31:0] word;
  logic        advance;
  logic        load;

  assign above = (adc_sample_data_p > adc_threshold_p);

`ifdef PULSE_MIN_WIDTH_FILTER_EN
  assign keep = (width >= 16'(MIN_PULSE_WIDTH));
`else
  logic [15:0] unused_min_width;
  assign unused_min_width = 16'(MIN_PULSE_WIDTH);
  assign keep = 1'b1;
`endif

  assign push = (state == ST_EMIT) && keep;

  always_comb begin
    record = '0;
    record[TIME_LSB +: 64]                = start_time;
    record[PEAK_LSB +: 16]                = peak;
    record[WIDTH_LSB +: 16]               = width;
    record[FLAGS_LSB + FLAG_WIDTH_SAT]    = &width;
    record[FLAGS_LSB + FLAG_THR_CHANGED]  = thr_changed;
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state              <= ST_IDLE;
      start_time         <= '0;
      peak               <= '0;
      width              <= '0;
      start_thr          <= '0;
      thr_changed        <= 1'b0;
      event_drop_count_p <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (adc_sample_valid_p && above && timekeeper_ready_p) begin
            state       <= ST_IN_PULSE;
            start_time  <= timekeeper_time_p;
            peak        <= adc_sample_data_p;
            width       <= 16'd1;
            start_thr   <= adc_threshold_p;
            thr_changed <= 1'b0;
          end
        end
        ST_IN_PULSE: begin
          if (adc_sample_valid_p) begin
            if (adc_threshold_p != start_thr) thr_changed <= 1'b1;
            if (above) begin
              if (width != 16'hFFFF) width <= width + 16'd1;
              if (adc_sample_data_p > peak) peak <= adc_sample_data_p;
            end else begin
              state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          // Full is the pre-edge level: a same-cycle pop does not make room.
          if (keep && fifo_full && event_drop_count_p != 16'hFFFF)
            event_drop_count_p <= event_drop_count_p + 16'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  event_record_fifo #(
    .DEPTH (EVENT_FIFO_DEPTH),
    .WIDTH (RECORD_W)
  ) u_fifo (
    .clk       (clk210_p),
    .rst_n     (reset_n_p),
    .push      (push),
    .push_data (record),
    .pop       (load),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_p)
  );

  // Reloading on the handshake of word 3 lets records stream with no idle gap.
  assign advance = ser_valid && readout.event_ready_p;
  assign load    = (!ser_valid || (advance && word_idx == 2'd3)) && !fifo_empty;

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      ser_valid <= 1'b0;
      word_idx  <= '0;
      cur       <= '0;
    end else if (load) begin
      cur       <= fifo_rdata;
      ser_valid <= 1'b1;
      word_idx  <= '0;
    end else if (advance) begin
      if (word_idx == 2'd3) ser_valid <= 1'b0;
      word_idx <= word_idx + 2'd1;
    end
  end

  logic [7:0] unused_flags_hi;
  assign unused_flags_hi = cur[FLAGS_LSB + 8 +: 8];

  always_comb begin
    word = '0;
    case (word_idx)
      2'd0:    word = {HEADER, cur[FLAGS_LSB +: 8], cur[PEAK_LSB +: 16]};
      2'd1:    word = cur[TIME_LSB + 32 +: 32];
      2'd2:    word = cur[TIME_LSB +: 32];
      default: word = {cur[WIDTH_LSB +: 16], 16'h0000};
    endcase
  end

  assign readout.event_data_p  = ser_valid ? word : '0;
  assign readout.event_valid_p = ser_valid;
  assign readout.event_last_p  = ser_valid && (word_idx == 2'd3);
endmodule
